// File: rtl/vga_timing_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_controller_if: upstream pixel valid/ready handshake   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface vga_timing_controller_if #(
  parameter int COLOR_WIDTH = 4
);
  logic                   pix_valid;
  logic [COLOR_WIDTH-1:0] pix_red;
  logic [COLOR_WIDTH-1:0] pix_green;
  logic [COLOR_WIDTH-1:0] pix_blue;
  logic                   pix_ready;

  modport master (
    output pix_valid, pix_red, pix_green, pix_blue,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_red, pix_green, pix_blue,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_controller: VGA h/v timing, sync and pixel pull       |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module vga_timing_controller #(
  parameter int COLOR_WIDTH = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   enable,
  vga_timing_controller_if.slave      pix,
  input  wire logic                   underflow_clr,
  output logic [HW-1:0]               h_cnt,
  output logic [VW-1:0]               v_cnt,
  output logic                        frame_start,
  output logic                        underflow,
  output logic                        HSync,
  output logic                        VSync,
  output logic [COLOR_WIDTH-1:0]      RED,
  output logic [COLOR_WIDTH-1:0]      GREEN,
  output logic [COLOR_WIDTH-1:0]      BLUE
);

  localparam logic [HW-1:0] c_h_active  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_h_last    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_h_sync_lo = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_h_sync_hi = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] c_v_active  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_v_last    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_v_sync_lo = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_v_sync_hi = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          c_sync_on   = (SYNC_POL != 0);

  logic [HW-1:0]          r_h_cnt;
  logic [VW-1:0]          r_v_cnt;
  logic                   r_hsync;
  logic                   r_vsync;
  logic [COLOR_WIDTH-1:0] r_red;
  logic [COLOR_WIDTH-1:0] r_green;
  logic [COLOR_WIDTH-1:0] r_blue;
  logic                   r_frame_start;
  logic                   r_underflow;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_xfer;
  logic w_underrun;
  logic w_h_in_sync;
  logic w_v_in_sync;

  assign w_h_wrap    = (r_h_cnt == c_h_last);
  assign w_v_wrap    = (r_v_cnt == c_v_last);
  assign w_active    = enable && (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
  assign w_xfer      = w_active && pix.pix_valid;
  assign w_underrun  = w_active && !pix.pix_valid;
  assign w_h_in_sync = (r_h_cnt >= c_h_sync_lo) && (r_h_cnt <= c_h_sync_hi);
  assign w_v_in_sync = (r_v_cnt >= c_v_sync_lo) && (r_v_cnt <= c_v_sync_hi);

  // Ready depends only on position so the source never sees a combinational loop.
  assign pix.pix_ready = w_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~c_sync_on;
      r_vsync       <= ~c_sync_on;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (!enable) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~c_sync_on;
      r_vsync       <= ~c_sync_on;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end
      r_hsync       <= w_h_in_sync ? c_sync_on : ~c_sync_on;
      r_vsync       <= w_v_in_sync ? c_sync_on : ~c_sync_on;
      // Missing pixels and blanking both emit black.
      r_red         <= w_xfer ? pix.pix_red   : '0;
      r_green       <= w_xfer ? pix.pix_green : '0;
      r_blue        <= w_xfer ? pix.pix_blue  : '0;
      r_frame_start <= w_active && (r_h_cnt == '0) && (r_v_cnt == '0);
      if (w_underrun) begin
        r_underflow <= 1'b1;
      end else if (underflow_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;
  assign HSync       = r_hsync;
  assign VSync       = r_vsync;
  assign RED         = r_red;
  assign GREEN       = r_green;
  assign BLUE        = r_blue;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_timing_controller: directed bench on a reduced raster     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_vga_timing_controller;

  // Reduced raster: 15 clocks per line, 8 lines per frame, 120 clocks per frame.
  localparam int CW    = 4;
  localparam int H_TOT = 15;
  localparam int FRAME = 120;
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int HS_LO = 10;
  localparam int HS_HI = 12;
  localparam int VS_LO = 5;
  localparam int VS_HI = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          underflow_clr;
  logic [3:0]    h_cnt;
  logic [2:0]    v_cnt;
  logic          frame_start;
  logic          underflow;
  logic          HSync;
  logic          VSync;
  logic [CW-1:0] RED;
  logic [CW-1:0] GREEN;
  logic [CW-1:0] BLUE;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int exp_uf   = 0;
  int fs_cnt   = 0;
  int vs_low   = 0;

  vga_timing_controller_if #(.COLOR_WIDTH(CW)) pix_if ();

  vga_timing_controller #(
    .COLOR_WIDTH(CW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .pix(pix_if.slave),
    .underflow_clr(underflow_clr),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .frame_start(frame_start),
    .underflow(underflow),
    .HSync(HSync),
    .VSync(VSync),
    .RED(RED),
    .GREEN(GREEN),
    .BLUE(BLUE)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t pos=%0d)", tag, obs, exp, $time, pos);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_h_cnt"}, h_cnt, 0);
    check_val({tag, "_v_cnt"}, v_cnt, 0);
    check_val({tag, "_hsync"}, HSync, 1);
    check_val({tag, "_vsync"}, VSync, 1);
    check_val({tag, "_red"}, RED, 0);
    check_val({tag, "_green"}, GREEN, 0);
    check_val({tag, "_blue"}, BLUE, 0);
    check_val({tag, "_frame_start"}, frame_start, 0);
  endtask

  // One clock: drive inputs for the current raster position, then check the registered result.
  task automatic step(input logic en, input logic vld, input logic clr);
    int h;
    int v;
    logic act;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    h   = pos % H_TOT;
    v   = pos / H_TOT;
    act = en && (h < H_ACT) && (v < V_ACT);
    r   = 4'(pos);
    g   = 4'(pos >> 4);
    b   = 4'(pos * 3);
    enable           = en;
    underflow_clr    = clr;
    pix_if.pix_valid = vld;
    pix_if.pix_red   = r;
    pix_if.pix_green = g;
    pix_if.pix_blue  = b;
    #1;
    check_val("pix_ready", pix_if.pix_ready, act);
    check_val("h_cnt", h_cnt, en ? h : (pos % H_TOT));
    check_val("v_cnt", v_cnt, v);
    @(posedge clk);
    #1;
    if (en) begin
      check_val("hsync", HSync, (h >= HS_LO && h <= HS_HI) ? 0 : 1);
      check_val("vsync", VSync, (v >= VS_LO && v <= VS_HI) ? 0 : 1);
      check_val("red", RED, (act && vld) ? int'(r) : 0);
      check_val("green", GREEN, (act && vld) ? int'(g) : 0);
      check_val("blue", BLUE, (act && vld) ? int'(b) : 0);
      check_val("frame_start", frame_start, (act && pos == 0) ? 1 : 0);
      if (act && !vld) exp_uf = 1;
      else if (clr) exp_uf = 0;
      pos = (pos + 1) % FRAME;
    end else begin
      check_idle_outputs("disabled");
      pos = 0;
    end
    check_val("underflow", underflow, exp_uf);
    if (frame_start) fs_cnt++;
    if (!VSync) vs_low++;
  endtask

  initial begin
    rst_n            = 1'b0;
    enable           = 1'b0;
    underflow_clr    = 1'b0;
    pix_if.pix_valid = 1'b0;
    pix_if.pix_red   = '0;
    pix_if.pix_green = '0;
    pix_if.pix_blue  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_val("reset_underflow", underflow, 0);
    check_val("reset_pix_ready", pix_if.pix_ready, 0);

    rst_n = 1'b1;
    repeat (2 * FRAME) step(1'b1, 1'b1, 1'b0);
    check_val("frame_start_count", fs_cnt, 2);
    check_val("vsync_low_cycles", vs_low, 60);

    // Starve the output at line 1, pixel 3.
    while (pos != H_TOT + 3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0);
    while (pos != 3 * H_TOT + 2) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_val("uf_set_wins", underflow, 1);

    // Disable mid-line with underflow pending; it must survive.
    while (pos != 3 * H_TOT + 5) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check_val("uf_hold_disabled", underflow, 1);
    step(1'b1, 1'b1, 1'b0);
    check_val("restart_frame_start", frame_start, 1);
    repeat (5) step(1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check_val("async_rst_underflow", underflow, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pos    = 0;
    exp_uf = 0;
    repeat (20) step(1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
